// File: rtl/aidc_lite_ahb_slv_mem_if.sv
// AHB-Lite bus bundle for the 64-bit memory slave.
// Handshake: an address phase is taken on a rising edge with hsel=1, hready=1 and
// htrans NONSEQ/SEQ. The data phase ends on the first edge where hreadyout=1.
// hwdata must stay stable through the whole data phase.
interface aidc_lite_ahb_slv_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [63:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/aidc_lite_ahb_slv_mem.sv
// AHB-Lite 64-bit memory slave with programmable wait states and byte-lane writes.
// Define AIDC_LITE_AHB_SLV_ERR_EN to enable the two-cycle ERROR response path.
module aidc_lite_ahb_slv_mem #(
  parameter int          MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aidc_lite_ahb_slv_mem_if.slave  bus,
  output logic [2:0]              dbg_state,
  output logic [2:0]              dbg_hburst
);

  localparam int        IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] haddr_r;
  logic        hwrite_r;
  logic [2:0]  hsize_r;
  logic [2:0]  hburst_r;
  logic        hreadyout_r;

  logic [63:0] mem [MEM_DEPTH];

  logic        can_accept;
  logic        accept;
  logic [31:0] word_offs;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]  eff_size;
  logic [7:0]  lane_mask;

  // New transfers are only taken in cycles where this slave drives hreadyout high.
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept && bus.hsel && bus.hready &&
                      ((bus.htrans == 2'b10) || (bus.htrans == 2'b11));

`ifdef AIDC_LITE_AHB_SLV_ERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd8;
  logic [31:0] req_offs;
  logic        req_err;
  logic        hresp_r;

  // Addresses below BASE_ADDR wrap to a large offset and fail the range test too.
  assign req_offs = bus.haddr - BASE_ADDR;
  assign req_err  = ({1'b0, req_offs} >= MEM_BYTES) || (bus.hsize > 3'd3);
  assign bus.hresp = hresp_r;
`else
  assign bus.hresp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      haddr_r     <= 32'd0;
      hwrite_r    <= 1'b0;
      hsize_r     <= 3'd0;
      hburst_r    <= 3'd0;
      hreadyout_r <= 1'b1;
`ifdef AIDC_LITE_AHB_SLV_ERR_EN
      hresp_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= S_DATA;
            hreadyout_r <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`ifdef AIDC_LITE_AHB_SLV_ERR_EN
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
`endif
        default: begin
          if (accept) begin
            haddr_r  <= bus.haddr;
            hwrite_r <= bus.hwrite;
            hsize_r  <= bus.hsize;
            hburst_r <= bus.hburst;
`ifdef AIDC_LITE_AHB_SLV_ERR_EN
            hresp_r  <= req_err;
            if (req_err) begin
              state       <= S_ERR1;
              hreadyout_r <= 1'b0;
            end else
`endif
            if (WAIT_CYCLES > 0) begin
              state       <= S_WAIT;
              wait_cnt    <= WAIT_LOAD;
              hreadyout_r <= 1'b0;
            end else begin
              state       <= S_DATA;
              hreadyout_r <= 1'b1;
            end
          end else begin
            state       <= S_IDLE;
            hreadyout_r <= 1'b1;
`ifdef AIDC_LITE_AHB_SLV_ERR_EN
            hresp_r     <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  // Word index wraps modulo MEM_DEPTH when out-of-range addresses are not trapped.
  assign word_offs = haddr_r - BASE_ADDR;
  assign word_idx  = IDX_W'(word_offs >> 3);
  assign eff_size  = (hsize_r > 3'd3) ? 2'd3 : hsize_r[1:0];

  always_comb begin
    lane_mask = 8'hFF;
    case (eff_size)
      2'd0:    lane_mask = 8'h01 << haddr_r[2:0];
      2'd1:    lane_mask = 8'h03 << {haddr_r[2:1], 1'b0};
      2'd2:    lane_mask = 8'h0F << {haddr_r[2], 2'b00};
      default: lane_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if ((state == S_DATA) && hwrite_r) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_mask[i]) mem[word_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hrdata    = ((state == S_DATA) && !hwrite_r) ? mem[word_idx] : 64'd0;
  assign bus.hreadyout = hreadyout_r;
  assign dbg_state     = state;
  assign dbg_hburst    = hburst_r;

endmodule

// File: doc/aidc_lite_ahb_slv_mem.md
AIDC_LITE_AHB_SLV_MEM -- requirements
Module: AIDC_LITE_AHB_SLV_MEM

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 64-bit words; power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base address of the memory; aligned to MEM_DEPTH*8.
REQ-003 Parameter WAIT_CYCLES, default 0, range 0..15, wait states inserted per transfer.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 hsel  input  1  slave select.
REQ-007 haddr  input  32  byte address.
REQ-008 htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 hwrite  input  1  1=write, 0=read.
REQ-010 hsize  input  3  transfer size, 2^hsize bytes.
REQ-011 hburst  input  3  burst type; accepted, not decoded.
REQ-012 hwdata  input  64  write data, valid in data phase.
REQ-013 hready  input  1  bus-level ready; address phase accepted only when high.
REQ-014 hreadyout  output  1  slave ready; low extends the data phase.
REQ-015 hresp  output  1  0=OKAY, 1=ERROR.
REQ-016 hrdata  output  64  read data.

Function
REQ-017 Transfer accepted when hsel=1, hready=1, htrans[1]=1; haddr, hwrite and hsize are registered at that edge. The next cycle starts the data phase.
REQ-018 IDLE/BUSY, or hsel=0 with hready=1: no transfer; next cycle hreadyout=1, hresp=0 (zero-wait OKAY).
REQ-019 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE->WAIT on accept with WAIT_CYCLES>0.
- IDLE->DATA on accept with WAIT_CYCLES=0.
- IDLE->ERR1 on accept with an error condition (REQ-025).
REQ-020 WAIT: hreadyout=0 for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter; then DATA.
REQ-021 DATA: hreadyout=1 for one cycle. A transfer accepted in the same cycle re-enters WAIT/DATA/ERR1 (back-to-back pipelining); otherwise the FSM returns to IDLE.
REQ-022 Write commit: on the DATA-cycle edge, write bytes of hwdata into mem[(haddr_r-BASE_ADDR)>>3].
- Lane mask: 2^hsize_r contiguous bytes starting at haddr_r[2:0].
- hsize_r>=3 writes all 8 lanes.
- Unaligned transfers are masked to the naturally aligned lanes.
REQ-023 Read: during DATA, hrdata = mem[word index of haddr_r], full 64 bits, combinational. Outside a read DATA cycle, hrdata=0.
REQ-024 Coherency: a read immediately following a write to the same word returns the newly written bytes, because the write commits before the read data phase.
REQ-025 ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1. No memory write occurs. A transfer accepted during ERR2 is handled as in REQ-021. A transfer presented during ERR1 is not accepted, since hready=0.
REQ-026 No wait states are inserted before ERR1, regardless of WAIT_CYCLES.

Reset
REQ-027 While rst_n=0: state=IDLE, counter=0, hreadyout=1, hresp=0, hrdata=0, address/control registers=0.
REQ-028 Reset mid-transfer abandons the transfer with no write. Memory array contents are not reset.

Configuration
REQ-029 With macro AIDC_LITE_AHB_SLV_ERR_EN defined, these accepted transfers take the two-cycle ERROR path:
- haddr outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*8-1];
- hsize>3.
REQ-030 Without AIDC_LITE_AHB_SLV_ERR_EN: no error path exists (ERR1/ERR2 absent) and hresp is tied to 0. The word index wraps modulo MEM_DEPTH, and hsize>3 is treated as hsize=3.

Verification
REQ-031 WAIT_CYCLES=0: write 64'h0123_4567_89AB_CDEF to 32'h10 (hsize=3), then read 32'h10 -> hreadyout never low; read data equals the written value.
REQ-032 WAIT_CYCLES=3: single read -> hreadyout low exactly 3 cycles, then high 1 cycle with data.
REQ-033 Pre-fill word 0 with 0, then byte write (hsize=0) of 8'hA5 at 32'h5 -> read of word 0 returns 64'h0000_A500_0000_0000.
REQ-034 INCR4 write of 1,2,3,4 at 32'h20 with WAIT_CYCLES=0, followed back-to-back by a read of 32'h28 -> every DATA cycle OKAY; the read returns 2.
REQ-035 With ERR_EN, access to BASE_ADDR+MEM_DEPTH*8 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); memory unchanged. Without ERR_EN, the same access aliases word 0.
REQ-036 rst_n pulled low during WAIT of a write -> outputs reach their reset values asynchronously; the target word is unchanged; the next transfer completes normally.
